// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_ctrl
// Purpose  : Multiplexed scan controller for N common-anode 7-segment digits.
//            The packed nibbles and per-digit masks are captured into shadow
//            registers once per frame, so a digit never changes while it is
//            partly lit. Each digit slot starts with GUARD cycles of all
//            anodes off, which prevents ghosting between digits. The glyph
//            set is hex or decimal; in decimal mode nibbles 10..15 show a
//            dash.
// Ports    : clk         - clock
//            reset       - synchronous, active-high reset
//            digits      - 4*N_DIGITS packed nibbles, digit 0 is rightmost
//            hex_mode    - 1: A..F glyphs, 0: dash for nibbles 10..15
//            dp_mask     - per-digit decimal point enable
//            blank_mask  - per-digit force-dark
//            blink_mask  - per-digit blink enable
//            anodes_n    - active-low digit enables (registered)
//            cathodes_n  - active-low segments {a..g}, bit 6 = a (registered)
//            dp_n        - active-low decimal point (registered)
//            frame_start - one-cycle pulse, one cycle after each shadow load
// Config   : define SEG7_BLINK_EN to build the blink logic. Without it,
//            blink_mask has no effect.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_ctrl #(
    parameter int N_DIGITS     = 8,
    parameter int SCAN_DIV     = 100000,
    parameter int GUARD        = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*N_DIGITS-1:0] digits,
    input  logic                  hex_mode,
    input  logic [N_DIGITS-1:0]   dp_mask,
    input  logic [N_DIGITS-1:0]   blank_mask,
    input  logic [N_DIGITS-1:0]   blink_mask,
    output logic [N_DIGITS-1:0]   anodes_n,
    output logic [6:0]            cathodes_n,
    output logic                  dp_n,
    output logic                  frame_start
);

    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [PRE_W-1:0] c_PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(N_DIGITS - 1);

    // Scan counters and shadow registers
    logic [PRE_W-1:0]      r_pre;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_first;
    logic [4*N_DIGITS-1:0] r_sh_digits;
    logic [N_DIGITS-1:0]   r_sh_dp;
    logic [N_DIGITS-1:0]   r_sh_blank;
    logic                  r_sh_hex;

    // Registered outputs
    logic [N_DIGITS-1:0]   r_anodes_n;
    logic [6:0]            r_cathodes_n;
    logic                  r_dp_n;
    logic                  r_frame_start;

    // Combinational selection for the current slot
    logic                  w_tick;
    logic                  w_tick_load;
    logic                  w_load;
    logic [3:0]            w_nibble;
    logic                  w_dp_sel;
    logic                  w_blank_sel;
    logic                  w_blink_dark;
    logic                  w_guard_ok;
    logic                  w_lit;
    logic [6:0]            w_glyph;
    logic [N_DIGITS-1:0]   w_anodes_next;

    // Active-low segment patterns {a,b,c,d,e,f,g}
    function automatic logic [6:0] f_glyph(input logic [3:0] nib, input logic hex);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        // Decimal mode shows a dash for any non-decimal nibble
        if (!hex && (nib > 4'd9)) begin
            seg = 7'b1111110;
        end
        return seg;
    endfunction

    assign w_tick      = (r_pre == c_PRE_LAST);
    assign w_tick_load = w_tick && (r_idx == c_IDX_LAST);
    // The first cycle out of reset also loads, so a display is valid
    // without waiting a whole frame.
    assign w_load      = w_tick_load || r_first;

    // ------------------------------------------------------------------
    // Prescaler, slot index and shadow capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pre       <= '0;
            r_idx       <= '0;
            r_first     <= 1'b1;
            r_sh_digits <= '0;
            r_sh_dp     <= '0;
            r_sh_blank  <= '1;
            r_sh_hex    <= 1'b0;
        end else begin
            r_first <= 1'b0;
            r_pre   <= w_tick ? '0 : r_pre + 1'b1;
            if (w_tick) begin
                r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
            end
            if (w_load) begin
                r_sh_digits <= digits;
                r_sh_dp     <= dp_mask;
                r_sh_blank  <= blank_mask;
                r_sh_hex    <= hex_mode;
            end
        end
    end

    // ------------------------------------------------------------------
    // Blink phase: toggles every BLINK_FRAMES full frames
    // ------------------------------------------------------------------
`ifdef SEG7_BLINK_EN
    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FC_W-1:0] c_FC_LAST = FC_W'(BLINK_FRAMES - 1);

    logic [N_DIGITS-1:0] r_sh_blink;
    logic [FC_W-1:0]     r_frame_cnt;
    logic                r_blink_phase;
    logic                w_blink_sel;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sh_blink    <= '0;
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else begin
            if (w_load) begin
                r_sh_blink <= blink_mask;
            end
            // Only frame-end loads count; the post-reset load starts frame 0
            if (w_tick_load) begin
                if (r_frame_cnt == c_FC_LAST) begin
                    r_frame_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_blink_sel = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_blink_sel = r_sh_blink[i];
            end
        end
    end

    assign w_blink_dark = r_blink_phase & w_blink_sel;
`else
    // Blink phase is permanently 0, so blink_mask never darkens a digit
    logic w_unused_blink;
    assign w_unused_blink = ^blink_mask;
    assign w_blink_dark   = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Current-slot selection and lighting decision
    // ------------------------------------------------------------------
    always_comb begin
        w_nibble    = '0;
        w_dp_sel    = 1'b0;
        w_blank_sel = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nibble    = r_sh_digits[4*i +: 4];
                w_dp_sel    = r_sh_dp[i];
                w_blank_sel = r_sh_blank[i];
            end
        end
    end

    // With no guard interval, the comparison would be constant-true
    generate
        if (GUARD == 0) begin : g_no_guard
            assign w_guard_ok = 1'b1;
        end else begin : g_guard
            localparam logic [PRE_W-1:0] c_GUARD = PRE_W'(GUARD);
            assign w_guard_ok = (r_pre >= c_GUARD);
        end
    endgenerate

    assign w_lit   = w_guard_ok && !w_blank_sel && !w_blink_dark;
    assign w_glyph = f_glyph(w_nibble, r_sh_hex);

    always_comb begin
        w_anodes_next = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (w_lit && (r_idx == IDX_W'(i))) begin
                w_anodes_next[i] = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output registers: one cycle behind counter and shadow state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_anodes_n    <= '1;
            r_cathodes_n  <= 7'h7F;
            r_dp_n        <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_anodes_n    <= w_anodes_next;
            r_cathodes_n  <= w_lit ? w_glyph : 7'h7F;
            r_dp_n        <= w_lit ? ~w_dp_sel : 1'b1;
            r_frame_start <= w_load;
        end
    end

    assign anodes_n    = r_anodes_n;
    assign cathodes_n  = r_cathodes_n;
    assign dp_n        = r_dp_n;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_ctrl
// Purpose  : Self-checking bench for seg7_scan_ctrl (N_DIGITS=4, SCAN_DIV=4,
//            GUARD=1, BLINK_FRAMES=2). It uses a frame/slot arithmetic
//            reference model with shadow contents stored per frame number.
//            Both blink builds are handled through SEG7_BLINK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_ctrl;

    localparam int N  = 4;
    localparam int SD = 4;
    localparam int GD = 1;
    localparam int BF = 2;
    localparam int FL = N * SD;   // frame length in cycles

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] digits = 16'h1234;
    logic        hex_mode = 1'b0;
    logic [3:0]  dp_mask = 4'h0;
    logic [3:0]  blank_mask = 4'h0;
    logic [3:0]  blink_mask = 4'h0;
    logic [3:0]  anodes_n;
    logic [6:0]  cathodes_n;
    logic        dp_n;
    logic        frame_start;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;   // cycles since the last reset edge

    // Shadow contents the model expects, indexed by frame number
    logic [15:0] m_dig   [0:255];
    logic        m_hex   [0:255];
    logic [3:0]  m_dp    [0:255];
    logic [3:0]  m_blank [0:255];
    logic [3:0]  m_blink [0:255];

    seg7_scan_ctrl #(
        .N_DIGITS     (N),
        .SCAN_DIV     (SD),
        .GUARD        (GD),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .digits      (digits),
        .hex_mode    (hex_mode),
        .dp_mask     (dp_mask),
        .blank_mask  (blank_mask),
        .blink_mask  (blink_mask),
        .anodes_n    (anodes_n),
        .cathodes_n  (cathodes_n),
        .dp_n        (dp_n),
        .frame_start (frame_start)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [6:0] ref_glyph(input logic [3:0] v, input logic hex);
        if (!hex && v > 4'd9) return 7'b1111110;
        case (v)
            4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;  default: return 7'b0111000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    // Advance one clock: capture the inputs the model expects the DUT to
    // load this cycle, then check all outputs #1 after the edge.
    task automatic step();
        int k, fr, pre, slot;
        logic [15:0] sd, t16;
        logic [3:0] sdp, sbl, sbk, t4;
        logic sh, ph, dark, lit;
        logic [3:0] e_an;
        logic [6:0] e_cat;
        logic e_dp, e_fs;
        if (!reset && ((cyc == 0) || ((cyc % FL) == FL - 1))) begin
            fr = (cyc == 0) ? 0 : (cyc + 1) / FL;
            m_dig[fr[7:0]]   = digits;
            m_hex[fr[7:0]]   = hex_mode;
            m_dp[fr[7:0]]    = dp_mask;
            m_blank[fr[7:0]] = blank_mask;
            m_blink[fr[7:0]] = blink_mask;
        end
        @(posedge clk);
        #1;
        if (reset) cyc = 0; else cyc++;
        if (cyc == 0) begin
            e_an = 4'hF; e_cat = 7'h7F; e_dp = 1'b1; e_fs = 1'b0;
        end else begin
            k    = cyc - 1;
            pre  = k % SD;
            slot = (k / SD) % N;
            fr   = k / FL;
            if (k == 0) begin
                sd = 16'h0; sdp = 4'h0; sbl = 4'hF; sbk = 4'h0; sh = 1'b0;
            end else begin
                sd = m_dig[fr[7:0]]; sdp = m_dp[fr[7:0]]; sbl = m_blank[fr[7:0]];
                sbk = m_blink[fr[7:0]]; sh = m_hex[fr[7:0]];
            end
            ph = 1'b0;
`ifdef SEG7_BLINK_EN
            ph = ((fr / BF) % 2) == 1;
`endif
            t4   = sbl >> slot;
            dark = t4[0];
            t4   = sbk >> slot;
            dark = dark || (ph && t4[0]);
            lit  = (pre >= GD) && !dark;
            t16  = sd >> (4 * slot);
            t4   = sdp >> slot;
            e_an  = lit ? ~(4'b0001 << slot) : 4'hF;
            e_cat = lit ? ref_glyph(t16[3:0], sh) : 7'h7F;
            e_dp  = lit ? ~t4[0] : 1'b1;
            e_fs  = (k == 0) || ((k % FL) == FL - 1);
        end
        chk("anodes_n", 7'(anodes_n), 7'(e_an));
        chk("cathodes_n", cathodes_n, e_cat);
        chk("dp_n", 7'(dp_n), 7'(e_dp));
        chk("frame_start", 7'(frame_start), 7'(e_fs));
    endtask

    // Step until the outputs show the given slot at the given prescaler value
    task automatic run_to(input int slot, input int pre);
        int n;
        logic reached;
        n = 0;
        reached = 1'b0;
        while (!reached && n < 3 * FL) begin
            step();
            n++;
            reached = (cyc >= 1) && (((cyc - 1) % SD) == pre) && ((((cyc - 1) / SD) % N) == slot);
        end
        checks++;
        assert (reached) else begin
            errors++;
            $error("FAIL run_to slot=%0d pre=%0d not reached in %0d cycles", slot, pre, n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset release with 1234
        repeat (3) step();
        chk("rst_anodes", 7'(anodes_n), 7'h0F);
        chk("rst_cath", cathodes_n, 7'h7F);
        reset = 1'b0;
        step();
        chk("s1_fs_first", 7'(frame_start), 7'h01);
        chk("s1_dark_first", 7'(anodes_n), 7'h0F);
        step();
        chk("s1_an_digit0", 7'(anodes_n), 7'b0001110);
        chk("s1_cat_digit0", cathodes_n, 7'b1001100);
        repeat (2 * FL) step();

        // 2: hex vs decimal glyphs
        digits = 16'h00AF; hex_mode = 1'b1;
        repeat (FL) step();
        run_to(0, 1); chk("s2_hex_F", cathodes_n, 7'b0111000);
        run_to(1, 1); chk("s2_hex_A", cathodes_n, 7'b0001000);
        hex_mode = 1'b0;
        repeat (FL) step();
        run_to(0, 1); chk("s2_dec_F", cathodes_n, 7'b1111110);
        run_to(1, 1); chk("s2_dec_A", cathodes_n, 7'b1111110);

        // 3: mid-frame change is deferred to the next frame
        digits = 16'h1234;
        repeat (FL) step();
        run_to(1, 1);
        digits = 16'h5678;
        run_to(2, 1); chk("s3_old_2", cathodes_n, 7'b0010010);
        run_to(3, 1); chk("s3_old_1", cathodes_n, 7'b1001111);
        run_to(0, 1); chk("s3_new_8", cathodes_n, 7'b0000000);

        // 4: decimal point and blanking
        dp_mask = 4'b0100; blank_mask = 4'b0001;
        repeat (FL) step();
        run_to(0, 2); chk("s4_blank_an", 7'(anodes_n), 7'h0F);
        run_to(2, 1); chk("s4_dp_on", 7'(dp_n), 7'h00);
        run_to(3, 1); chk("s4_dp_off", 7'(dp_n), 7'h01);

        // 5: blink of digit 1 over several half-periods
        dp_mask = 4'h0; blank_mask = 4'h0; blink_mask = 4'b0010;
        repeat (8 * FL) step();

        // 6: reset mid-frame
        run_to(2, 2);
        reset = 1'b1;
        step();
        chk("s6_rst_an", 7'(anodes_n), 7'h0F);
        chk("s6_rst_dp", 7'(dp_n), 7'h01);
        chk("s6_rst_fs", 7'(frame_start), 7'h00);
        reset = 1'b0;
        step();
        chk("s6_fs", 7'(frame_start), 7'h01);
        step();
        chk("s6_an_digit0", 7'(anodes_n), 7'b0001110);

        // 7: randomized inputs changed at random points
        for (int r = 0; r < 30; r++) begin
            digits     = 16'($urandom);
            hex_mode   = 1'($urandom);
            dp_mask    = 4'($urandom);
            blank_mask = 4'($urandom_range(0, 3) == 0 ? $urandom : 0);
            blink_mask = 4'($urandom);
            repeat ($urandom_range(1, 20)) step();
        end
        repeat (2 * FL) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
